axi_return_writer: RTL and testbench

- Parametrised successor to the conv return-path write-back block.
- Accepts result words from the calculate component and packs IN_WIDTH words into MEM_DATA_WIDTH beats in an internal FIFO.
- Writes a programmed number of beats to DDR over an AXI-4 write-only master, in bursts of up to BURST_LEN beats.
- Adds over the previous generation: partial final burst, beat-exact (not patch-granular) completion, flush of a partial pack, and a sticky BRESP error.

---
 rtl/axi_return_writer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_return_writer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_return_writer.sv
// ---------------------------------------------------------------------------
// axi_return_writer
//
// Return-path write-back engine. Result words from the calculate component
// are packed PACK = MEM_DATA_WIDTH/IN_WIDTH at a time into memory beats,
// buffered in a beat FIFO, and written to DDR through an AXI4 write-only
// master in INCR bursts of up to BURST_LEN beats until the programmed number
// of beats has been written.
//
// Optional build macro: RETURN_LANE_SWAP_EN
//   defined   -> wdata reverses the order of the 128-bit lanes of each beat
//   undefined -> wdata is the FIFO beat unchanged
//
// Ports:
//   system_clk, rst_n    clock, asynchronous active-low reset
//   start                one-cycle job start (ignored while busy)
//   base_addr            first burst address (burst-size aligned)
//   total_beats          number of packed beats in the job
//   in_data/in_valid     result word stream, in_ready = FIFO not full
//   flush                zero-pad and push a partially filled pack
//   busy, done, wr_err   job status (done pulses, wr_err sticky until start)
//   m_axi_aw*/w*/b*      AXI4 write address, data and response channels
// ---------------------------------------------------------------------------
module axi_return_writer #(
    parameter int IN_WIDTH       = 128,
    parameter int MEM_DATA_WIDTH = 512,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int BURST_LEN      = 64,
    parameter int FIFO_DEPTH     = 128
) (
    input  logic                        system_clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [MEM_ADDR_WIDTH-1:0]   base_addr,
    input  logic [23:0]                 total_beats,
    input  logic [IN_WIDTH-1:0]         in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        busy,
    output logic                        done,
    output logic                        wr_err,
    output logic [MEM_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [MEM_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [MEM_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready
);
    localparam int PACK   = MEM_DATA_WIDTH / IN_WIDTH;
    localparam int PACK_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int SIZE   = $clog2(MEM_DATA_WIDTH / 8);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANES  = MEM_DATA_WIDTH / 128;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    genvar gi;

    // ---------------- packer ----------------
    logic [PACK_W-1:0]         pack_cnt_reg;
    logic [MEM_DATA_WIDTH-1:0] pack_reg;
    logic [MEM_DATA_WIDTH-1:0] pack_merged;
    logic                      word_take;
    logic                      pack_last;
    logic                      push;
    logic                      pop;

    // ---------------- FIFO ----------------
    logic [MEM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          fifo_count_reg;
    logic [MEM_DATA_WIDTH-1:0] fifo_rd;
    logic [MEM_DATA_WIDTH-1:0] beat_out;

    // ---------------- job / FSM ----------------
    state_t                    state_reg, state_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg;
    logic [23:0]               remaining_reg;
    logic [7:0]                len_m1_reg;
    logic [7:0]                beat_cnt_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic                      wr_err_reg;
    logic [8:0]                cur_len;
    logic [8:0]                burst_len;
    logic [23:0]               rem_after;

    assign in_ready  = (fifo_count_reg < CNT_W'(FIFO_DEPTH));
    assign word_take = in_valid & in_ready;
    assign pack_last = (32'(pack_cnt_reg) == PACK - 1);

    // The incoming word is merged into its lane first, so a flush in the same
    // cycle pushes the pack including that word. Unfilled lanes are zero
    // because pack_reg is cleared after every push.
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_pack_lane
            assign pack_merged[gi*IN_WIDTH +: IN_WIDTH] =
                (word_take && pack_cnt_reg == PACK_W'(gi)) ? in_data
                                                           : pack_reg[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    // A lone flush with an empty pack does nothing; a flush while the FIFO
    // is full is dropped rather than overflowing it.
    assign push = in_ready &
                  ((word_take & pack_last) | (flush & (word_take | (pack_cnt_reg != '0))));
    assign pop  = m_axi_wvalid & m_axi_wready;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg     <= '0;
            pack_cnt_reg <= '0;
        end else if (push) begin
            pack_reg     <= '0;
            pack_cnt_reg <= '0;
        end else if (word_take) begin
            pack_reg     <= pack_merged;
            pack_cnt_reg <= pack_cnt_reg + PACK_W'(1);
        end
    end

    // Storage carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge system_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= pack_merged;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Show-ahead read: the head beat is on wdata as soon as W starts.
    assign fifo_rd = fifo_mem[rd_ptr_reg];

`ifdef RETURN_LANE_SWAP_EN
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_swap
            assign beat_out[gi*128 +: 128] = fifo_rd[(LANES-1-gi)*128 +: 128];
        end
    endgenerate
`else
    assign beat_out = fifo_rd;
`endif

    // ---------------- burst control ----------------
    assign cur_len   = (remaining_reg >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : remaining_reg[8:0];
    assign burst_len = {1'b0, len_m1_reg} + 9'd1;
    assign rem_after = remaining_reg - {15'd0, burst_len};

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (busy_reg && remaining_reg != '0 &&
                    32'(fifo_count_reg) >= 32'(cur_len)) begin
                    state_next = S_AW;
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_next = S_W;
            end
            S_W: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready && m_axi_wlast) state_next = S_B;
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            len_m1_reg    <= '0;
            beat_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            wr_err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !busy_reg) begin
                        addr_reg      <= base_addr;
                        remaining_reg <= total_beats;
                        wr_err_reg    <= 1'b0;
                        busy_reg      <= 1'b1;
                    end else if (busy_reg && remaining_reg == '0) begin
                        // zero-length job: finish one cycle after start
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else if (state_next == S_AW) begin
                        len_m1_reg <= 8'(cur_len - 9'd1);
                    end
                end
                S_AW: begin
                    if (m_axi_awready) beat_cnt_reg <= '0;
                end
                S_W: begin
                    if (m_axi_wready) beat_cnt_reg <= beat_cnt_reg + 8'd1;
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) wr_err_reg <= 1'b1;
                        remaining_reg <= rem_after;
                        addr_reg      <= addr_reg + (MEM_ADDR_WIDTH'(burst_len) << SIZE);
                        if (rem_after == '0) begin
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign wr_err        = wr_err_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awlen   = len_m1_reg;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_wdata   = (state_reg == S_W) ? beat_out : '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_reg == S_W) && (beat_cnt_reg == len_m1_reg);

endmodule

// File: tb/tb_axi_return_writer.sv
// ---------------------------------------------------------------------------
// tb_axi_return_writer
//
// Randomized bench for axi_return_writer with a queue-based reference model:
// accepted words are packed into expected beats, bursts are predicted from
// the job's remaining beat count and address, and every AW/W/B handshake,
// in_ready, busy, done and wr_err is compared against the model. A small
// AXI slave drives randomized ready/response timing.
// ---------------------------------------------------------------------------
module tb_axi_return_writer;
    localparam int IW   = 128;
    localparam int DW   = 512;
    localparam int AW   = 32;
    localparam int BL   = 64;
    localparam int FD   = 128;
    localparam int PACK = DW / IW;

    logic              system_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [23:0]       total_beats = '0;
    logic [IW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              busy, done, wr_err;
    logic [AW-1:0]     m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awlock;
    logic [3:0]        m_axi_awcache;
    logic [2:0]        m_axi_awprot;
    logic [3:0]        m_axi_awqos;
    logic              m_axi_awvalid;
    logic              m_axi_awready = 1'b0;
    logic [DW-1:0]     m_axi_wdata;
    logic [DW/8-1:0]   m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid;
    logic              m_axi_wready = 1'b0;
    logic [1:0]        m_axi_bresp = 2'b00;
    logic              m_axi_bvalid = 1'b0;
    logic              m_axi_bready;

    axi_return_writer dut (
        .system_clk(system_clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .total_beats(total_beats),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .busy(busy), .done(done), .wr_err(wr_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 system_clk = ~system_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_map(input logic [DW-1:0] b);
        logic [DW-1:0] r;
`ifdef RETURN_LANE_SWAP_EN
        for (int i = 0; i < DW / 128; i++) r[i*128 +: 128] = b[(DW/128-1-i)*128 +: 128];
`else
        r = b;
`endif
        return r;
    endfunction

    // ---------------- reference model state ----------------
    logic [IW-1:0] pk_words[$];
    logic [DW-1:0] exp_beats[$];
    int            m_count = 0;
    bit            m_busy = 0;
    bit            m_err = 0;
    int            done_due = 0;
    int            job_rem = 0;
    logic [AW-1:0] job_addr = '0;
    int            cur_len = 0;
    int            beat_idx = 0;
    bit            wlast_fire = 0;
    bit            b_fire = 0;

    // ---------------- slave control ----------------
    bit rand_aw = 0;
    bit rand_w = 0;
    int err_burst = -1;
    int bursts_done = 0;
    bit b_armed = 0;
    int b_delay = 0;

    // Monitor: sampled on the falling edge; handshakes seen here complete on
    // the following rising edge, so model updates describe post-edge state.
    always @(negedge system_clk) begin : monitor
        bit            exp_done;
        bit            push_ok;
        int            len;
        logic [DW-1:0] beat;
        if (!rst_n) begin
            pk_words.delete();
            exp_beats.delete();
            m_count = 0; m_busy = 0; m_err = 0; done_due = 0;
            job_rem = 0; cur_len = 0; beat_idx = 0;
            wlast_fire = 0; b_fire = 0;
        end else begin
            exp_done = (done_due == 1);
            check("in_ready", in_ready, m_count < FD);
            check("busy", busy, m_busy);
            check("wr_err", wr_err, m_err);
            if (done || exp_done) check("done", done, exp_done);
            if (done_due > 0) done_due--;

            if (start && !m_busy) begin
                m_busy = 1; m_err = 0;
                job_addr = base_addr; job_rem = int'(total_beats);
                if (total_beats == 0) done_due = 2;
                $display("START base=%h total=%0d", base_addr, total_beats);
            end

            push_ok = (m_count < FD);
            if (in_valid && in_ready) pk_words.push_back(in_data);
            if (push_ok && (pk_words.size() == PACK || (flush && pk_words.size() > 0))) begin
                beat = '0;
                foreach (pk_words[k]) beat[k*IW +: IW] = pk_words[k];
                exp_beats.push_back(beat);
                pk_words.delete();
                m_count++;
            end

            if (m_axi_awvalid && m_axi_awready) begin
                if (!(m_busy && job_rem != 0)) begin
                    check("aw_unexpected", m_axi_awvalid, 0);
                end else begin
                    len = (job_rem > BL) ? BL : job_rem;
                    check("awaddr", m_axi_awaddr, job_addr);
                    check("awlen", m_axi_awlen, len - 1);
                    cur_len = len; beat_idx = 0;
                    $display("AW addr=%h awlen=%0d", m_axi_awaddr, m_axi_awlen);
                end
            end

            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_beats.size() == 0) begin
                    check("w_unexpected", m_axi_wvalid, 0);
                end else begin
                    beat = exp_beats.pop_front();
                    m_count--;
                    check("wdata", m_axi_wdata, lane_map(beat));
                    check("wlast", m_axi_wlast, beat_idx == cur_len - 1);
                    beat_idx++;
                end
                if (m_axi_wlast) wlast_fire = 1;
            end

            if (m_axi_bvalid && m_axi_bready) begin
                check("b_beats", beat_idx, cur_len);
                if (m_axi_bresp != 2'b00) m_err = 1;
                job_rem -= cur_len;
                job_addr += AW'(cur_len * (DW / 8));
                b_fire = 1;
                $display("B bresp=%0d remaining=%0d", m_axi_bresp, job_rem);
                if (job_rem == 0) done_due = 1;
            end
            if (done_due == 1) m_busy = 0;
        end
    end

    // AXI slave: ready and response timing, updated just after the rising edge.
    always @(posedge system_clk) begin : slave
        #1;
        if (!rst_n) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0;
            m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; b_armed = 0;
        end else begin
            if (b_fire) begin m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; b_fire = 0; end
            if (wlast_fire) begin wlast_fire = 0; b_armed = 1; b_delay = $urandom_range(0, 3); end
            if (b_armed && !m_axi_bvalid) begin
                if (b_delay == 0) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (bursts_done == err_burst) ? 2'b10 : 2'b00;
                    bursts_done++;
                    b_armed = 0;
                end else begin
                    b_delay--;
                end
            end
            m_axi_awready = rand_aw ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = rand_w ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic feed_word(input logic [IW-1:0] w, input bit fl);
        bit ok = 0;
        int t = 0;
        in_valid = 1'b1; in_data = w; flush = fl;
        while (!ok && t < 3000) begin
            @(negedge system_clk);
            if (in_ready) ok = 1;
            t++;
        end
        if (!ok) check("in_accept_timeout", in_ready, 1);
        @(posedge system_clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic feed_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            feed_word({$urandom, $urandom, $urandom, $urandom}, 1'b0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge system_clk); #1;
            end
        end
    endtask

    task automatic pulse_flush();
        @(posedge system_clk); #1; flush = 1'b1;
        @(posedge system_clk); #1; flush = 1'b0;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input int n);
        @(posedge system_clk); #1;
        base_addr = b; total_beats = 24'(n); start = 1'b1;
        @(posedge system_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        int n = 0;
        while (!seen && n < limit) begin
            @(negedge system_clk);
            seen = done;
            n++;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge system_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_in_ready"}, in_ready, 1);
        check({phase, "_busy"}, busy, 0);
        check({phase, "_done"}, done, 0);
        check({phase, "_wr_err"}, wr_err, 0);
        check({phase, "_awvalid"}, m_axi_awvalid, 0);
        check({phase, "_wvalid"}, m_axi_wvalid, 0);
        check({phase, "_wlast"}, m_axi_wlast, 0);
        check({phase, "_bready"}, m_axi_bready, 0);
        check({phase, "_awaddr"}, m_axi_awaddr, 0);
        check({phase, "_awlen"}, m_axi_awlen, 0);
        check({phase, "_wdata"}, m_axi_wdata, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit seen;
        int n;
        repeat (3) @(posedge system_clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);
        check("awsize", m_axi_awsize, 3'd6);
        check("awburst", m_axi_awburst, 2'b01);
        check("wstrb", m_axi_wstrb, {(DW/8){1'b1}});

        // single full burst, always-ready slave
        start_job(32'h1000, 64);
        fork
            feed_words(256, 1'b0);
            wait_done(4000);
        join
        idle(4);

        // three bursts with a partial last one; error response on burst 2
        rand_w = 1; rand_aw = 1;
        err_burst = bursts_done + 1;
        start_job(32'h1000, 150);
        fork
            feed_words(600, 1'b1);
            wait_done(10000);
        join
        idle(4);
        check("wr_err_sticky", wr_err, 1);
        err_burst = -1;

        // zero-length job: done follows immediately, wr_err cleared by start
        start_job(32'h4000, 0);
        wait_done(10);
        idle(2);

        // partial packs: 6 words + flush, 2 words with flush on the second,
        // then a flush with an empty pack that must be ignored
        feed_words(6, 1'b0);
        pulse_flush();
        feed_word({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        feed_word({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        pulse_flush();
        start_job(32'h8000, 3);
        wait_done(2000);
        idle(4);

        // fill the FIFO with no job running, then drain with random wready
        feed_words(FD * PACK, 1'b0);
        idle(3);
        check("in_ready_full", in_ready, 0);
        start_job(32'h0001_0000, 200);
        fork
            feed_words(72 * PACK, 1'b1);
            wait_done(20000);
        join
        idle(4);

        // reset in the middle of a write burst, then a fresh job
        rand_w = 0; rand_aw = 0;
        feed_words(256, 1'b0);
        start_job(32'h2000, 64);
        seen = 0; n = 0;
        while (!seen && n < 300) begin
            @(negedge system_clk);
            seen = m_axi_wvalid && m_axi_wready;
            n++;
        end
        check("w_started", seen, 1);
        idle(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        idle(3);
        rst_n = 1'b1;
        idle(2);
        feed_words(64, 1'b0);
        start_job(32'h3000, 16);
        wait_done(2000);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
